// File: rtl/exotiny_mon_pkg.sv
// Shared types and defaults for the ExoTiny GPO monitor.
package exotiny_mon_pkg;

  localparam int          MON_TOGGLE_W    = 16;
  localparam int          MON_PASSCNT_DEF = 8;
  localparam logic [23:0] MON_TIMEOUT_DEF = 24'hFF_FFFF;

  typedef enum logic [1:0] {
    MON_IDLE,
    MON_MEASURE,
    MON_PASS,
    MON_FAIL
  } mon_state_e;

endpackage

// File: rtl/exotiny_edge_det.sv
// Capture stage, reference-level priming and edge detection for one GPO bit.
// Macro EXOTINY_GPO_MON_SYNC_EN selects a 2-flop synchronizer instead of a
// single capture register, for asynchronous pins on the FPGA harness.
module exotiny_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic toggled
);

  logic cap;
  logic cap_vld;
  logic prev;
  logic primed;

`ifdef EXOTINY_GPO_MON_SYNC_EN
  logic meta;
  logic meta_vld;

  // Two-stage synchronizer; the valid chain marks when cap holds a real sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 1'b0;
      cap      <= 1'b0;
      meta_vld <= 1'b0;
      cap_vld  <= 1'b0;
    end else begin
      meta     <= level;
      cap      <= meta;
      meta_vld <= 1'b1;
      cap_vld  <= meta_vld;
    end
  end
`else
  // Single capture register; valid from the first clock after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap     <= 1'b0;
      cap_vld <= 1'b0;
    end else begin
      cap     <= level;
      cap_vld <= 1'b1;
    end
  end
`endif

  // Track the previous captured level; the first valid sample becomes the reference.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev   <= 1'b0;
      primed <= 1'b0;
    end else if (cap_vld) begin
      prev   <= cap;
      primed <= 1'b1;
    end
  end

  assign toggled = primed && (cap != prev);

endmodule

// File: rtl/exotiny_gpo_monitor.sv
// Edge/period monitor on one ExoTiny GPO bit with sticky pass/fail flags.
// Optional macro EXOTINY_GPO_MON_SYNC_EN adds a synchronizer in the capture
// stage (one extra cycle of latency).
module exotiny_gpo_monitor
  import exotiny_mon_pkg::*;
#(
  parameter int              GPOCNT  = 1,
  parameter int              GPOSEL  = 0,
  parameter int              CNTW    = 24,
  parameter int              PASSCNT = MON_PASSCNT_DEF,
  parameter logic [CNTW-1:0] TIMEOUT = CNTW'(MON_TIMEOUT_DEF)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [GPOCNT-1:0]       gpo_i,
  input  logic [CNTW-1:0]         min_per_i,
  input  logic [CNTW-1:0]         max_per_i,
  output logic                    edge_o,
  output logic [CNTW-1:0]         period_o,
  output logic                    period_vld_o,
  output logic [MON_TOGGLE_W-1:0] toggles_o,
  output logic                    pass_o,
  output logic                    fail_o,
  output logic                    done_o
);

  localparam int              GOODW   = $clog2(PASSCNT + 1);
  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] TO_LAST = TIMEOUT - CNTW'(1);
  localparam logic [MON_TOGGLE_W-1:0] TOG_MAX = {MON_TOGGLE_W{1'b1}};

  logic             det_edge;
  logic [CNTW-1:0]  cnt;
  logic [GOODW-1:0] good;
  logic             in_window;
  logic             timeout_hit;
  mon_state_e       state;

  exotiny_edge_det u_edge_det (
    .clk     (clk_i),
    .rst     (rst_i),
    .level   (gpo_i[GPOSEL]),
    .toggled (det_edge)
  );

  assign in_window   = (period_o >= min_per_i) && (period_o <= max_per_i);
  assign timeout_hit = (cnt == TO_LAST) && !det_edge;
  assign done_o      = pass_o | fail_o;

  // Period counter plus the edge, period and toggle outputs, all registered together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt          <= '0;
      edge_o       <= 1'b0;
      period_o     <= '0;
      period_vld_o <= 1'b0;
      toggles_o    <= '0;
    end else begin
      edge_o       <= det_edge;
      period_vld_o <= det_edge && (state != MON_IDLE);
      if (det_edge) begin
        cnt <= '0;
        if (state != MON_IDLE) begin
          period_o <= (cnt == CNT_MAX) ? CNT_MAX : cnt + CNTW'(1);
        end
        if (toggles_o != TOG_MAX) begin
          toggles_o <= toggles_o + MON_TOGGLE_W'(1);
        end
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNTW'(1);
      end
    end
  end

  // Monitor FSM: judges each reported period and the stall timeout, then latches a verdict.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= MON_IDLE;
      good   <= '0;
      pass_o <= 1'b0;
      fail_o <= 1'b0;
    end else begin
      case (state)
        MON_IDLE: begin
          if (det_edge) begin
            state <= MON_MEASURE;
          end else if (cnt == TO_LAST) begin
            state  <= MON_FAIL;
            fail_o <= 1'b1;
          end
        end
        MON_MEASURE: begin
          if (period_vld_o) begin
            if (!in_window) begin
              state  <= MON_FAIL;
              fail_o <= 1'b1;
            end else if (int'(good) + 1 >= PASSCNT) begin
              state  <= MON_PASS;
              pass_o <= 1'b1;
            end else begin
              good <= good + GOODW'(1);
            end
          end else if (timeout_hit) begin
            state  <= MON_FAIL;
            fail_o <= 1'b1;
          end
        end
        MON_PASS: state <= MON_PASS;
        MON_FAIL: state <= MON_FAIL;
        default:  state <= MON_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exotiny_gpo_monitor.sv
// Self-checking bench for exotiny_gpo_monitor: directed scenarios with literal
// expectations plus randomized square waves, all compared every cycle against
// an edge-time reference model. Honours EXOTINY_GPO_MON_SYNC_EN for latency.
module tb_exotiny_gpo_monitor;

  localparam int CNTW    = 24;
  localparam int PASSCNT = 8;
  localparam int TIMEOUT = 100;
`ifdef EXOTINY_GPO_MON_SYNC_EN
  localparam int SE = 1;
`else
  localparam int SE = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [0:0]      gpo = 1'b0;
  logic [CNTW-1:0] min_per = CNTW'(8);
  logic [CNTW-1:0] max_per = CNTW'(12);
  logic            edge_o;
  logic [CNTW-1:0] period_o;
  logic            period_vld_o;
  logic [15:0]     toggles_o;
  logic            pass_o;
  logic            fail_o;
  logic            done_o;

  int tests = 0;
  int fails = 0;

  exotiny_gpo_monitor #(
    .GPOCNT  (1),
    .GPOSEL  (0),
    .CNTW    (CNTW),
    .PASSCNT (PASSCNT),
    .TIMEOUT (CNTW'(TIMEOUT))
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .gpo_i        (gpo),
    .min_per_i    (min_per),
    .max_per_i    (max_per),
    .edge_o       (edge_o),
    .period_o     (period_o),
    .period_vld_o (period_vld_o),
    .toggles_o    (toggles_o),
    .pass_o       (pass_o),
    .fail_o       (fail_o),
    .done_o       (done_o)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference model state: edges are timestamps, periods are differences.
  int m_p, m_last, m_good, e_period, e_tog;
  bit m_any, m_to, m_done, h0, h1, h2, seen, started;
  bit e_edge, e_vld, e_pass, e_fail, p_pass, p_fail;

  task automatic modelReset();
    m_p = 0; m_last = -1; m_good = 0; m_any = 0; m_to = 0; m_done = 0;
    e_edge = 0; e_vld = 0; e_pass = 0; e_fail = 0; p_pass = 0; p_fail = 0;
    e_period = 0; e_tog = 0;
  endtask

  task automatic modelStep(input bit smp);
    bit ed;
    int per;
    h2 = h1; h1 = h0; h0 = smp;
    ed = (SE == 0) ? (m_p >= 2 && h0 != h1) : (m_p >= 3 && h1 != h2);
    e_pass = e_pass | p_pass;
    e_fail = e_fail | p_fail;
    p_pass = 0; p_fail = 0;
    e_edge = ed;
    e_vld  = 0;
    if (ed) begin
      per = m_p - m_last;
      if (m_any || m_to) begin
        e_vld = 1;
        e_period = per;
        if (!m_done) begin
          if (per < int'(min_per) || per > int'(max_per)) begin
            p_fail = 1; m_done = 1;
          end else begin
            m_good++;
            if (m_good >= PASSCNT) begin
              p_pass = 1; m_done = 1;
            end
          end
        end
      end
      m_any = 1;
      m_last = m_p;
      if (e_tog < 65535) e_tog++;
    end else if (!m_done && (m_p - m_last - 1) == TIMEOUT - 1) begin
      e_fail = 1; m_done = 1; m_to = 1;
    end
    m_p++;
  endtask

  // Compare process: check this cycle, then advance the model by one cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        tests++;
        if (edge_o !== e_edge || period_vld_o !== e_vld || period_o !== CNTW'(e_period) ||
            toggles_o !== 16'(e_tog) || pass_o !== e_pass || fail_o !== e_fail ||
            done_o !== (e_pass | e_fail)) begin
          fails++;
          $display("[TB] FAIL cycle-compare t=%0t got edge=%0b vld=%0b per=%0d tog=%0d pass=%0b fail=%0b done=%0b want edge=%0b vld=%0b per=%0d tog=%0d pass=%0b fail=%0b done=%0b",
                   $time, edge_o, period_vld_o, period_o, toggles_o, pass_o, fail_o, done_o,
                   e_edge, e_vld, e_period, e_tog, e_pass, e_fail, e_pass | e_fail);
        end
      end
      if (rst) begin
        started = 1;
        modelReset();
      end else if (started) begin
        modelStep(seen);
      end
      seen = gpo[0];
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyReset(input bit lvl, input int mn, input int mx);
    rst = 1'b1;
    gpo = lvl;
    min_per = CNTW'(mn);
    max_per = CNTW'(mx);
    tick(2);
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input int hold);
    gpo = ~gpo;
    tick(hold);
  endtask

  // Directed scenarios followed by randomized runs.
  initial begin
    int edgeCount, firstAt, mn, mx, lo, hi, r, hold;
    applyReset(1'b0, 8, 12);

    // Good square wave: eight periods of 10 in [8,12].
    applyReset(1'b0, 8, 12);
    tick(5);
    repeat (8) applyStimulus(10);
    gpo = ~gpo;
    tick(2 + SE);
    checkOutput("square period_vld", period_vld_o, 1);
    checkOutput("square period", period_o, 10);
    checkOutput("square pass early", pass_o, 0);
    tick(1);
    checkOutput("square pass", pass_o, 1);
    checkOutput("square fail", fail_o, 0);
    checkOutput("square toggles", toggles_o, 9);

    // Short fifth period.
    applyReset(1'b0, 8, 12);
    tick(5);
    repeat (4) applyStimulus(10);
    applyStimulus(5);
    gpo = ~gpo;
    tick(2 + SE);
    checkOutput("short period", period_o, 5);
    checkOutput("short fail early", fail_o, 0);
    tick(1);
    checkOutput("short fail", fail_o, 1);
    checkOutput("short pass", pass_o, 0);

    // Stall from reset.
    applyReset(1'b0, 8, 12);
    tick(99);
    checkOutput("stall fail early", fail_o, 0);
    tick(1);
    checkOutput("stall fail", fail_o, 1);
    checkOutput("stall toggles", toggles_o, 0);

    // High level at reset release.
    applyReset(1'b1, 8, 12);
    tick(20);
    checkOutput("hi-reset no edge", toggles_o, 0);
    gpo = 1'b0;
    edgeCount = 0;
    firstAt = -1;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      if (edge_o) begin
        edgeCount++;
        if (firstAt < 0) firstAt = i;
      end
    end
    checkOutput("hi-reset edge count", edgeCount, 1);
    checkOutput("hi-reset edge latency", firstAt, 2 + SE);

    // Edge exactly at the timeout threshold.
    applyReset(1'b0, 8, 100);
    tick(5);
    applyStimulus(100);
    gpo = ~gpo;
    tick(2 + SE);
    checkOutput("threshold period", period_o, 100);
    checkOutput("threshold vld", period_vld_o, 1);
    tick(1);
    checkOutput("threshold fail", fail_o, 0);

    // Reset in MEASURE after three good periods.
    applyReset(1'b0, 8, 12);
    tick(5);
    repeat (4) applyStimulus(10);
    rst = 1'b1;
    tick(1);
    checkOutput("midreset outputs", {edge_o, period_vld_o, pass_o, fail_o, done_o}, 0);
    checkOutput("midreset period", period_o, 0);
    checkOutput("midreset toggles", toggles_o, 0);
    tick(1);
    rst = 1'b0;
    tick(5);
    repeat (8) applyStimulus(10);
    checkOutput("midreset pass early", pass_o, 0);
    gpo = ~gpo;
    tick(3 + SE);
    checkOutput("midreset pass", pass_o, 1);

    // Randomized windows and wave shapes.
    for (int run = 0; run < 14; run++) begin
      mn = $urandom_range(10, 3);
      mx = mn + $urandom_range(6, 0);
      if ($urandom_range(5, 0) == 0) begin
        hi = mn; mn = mx + 1; mx = hi;
      end
      lo = (mn < mx) ? mn : mx;
      hi = (mn < mx) ? mx : mn;
      applyReset(1'($urandom_range(1, 0)), mn, mx);
      tick($urandom_range(8, 0));
      repeat ($urandom_range(14, 4)) begin
        r = $urandom_range(19, 0);
        if (r == 0)      hold = $urandom_range(105, 95);
        else if (r < 3)  hold = $urandom_range(20, 1);
        else             hold = $urandom_range(hi, lo);
        applyStimulus(hold);
      end
      if ($urandom_range(3, 0) == 0) tick(110);
      else tick($urandom_range(10, 1));
    end

    tick(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
